// File: rtl/spi_xfer_ctrl.sv
// SPI master transfer sequencer: drives the serial-clock generator and shifts MOSI/MISO per edge pulse.
// Build option: define SPI_XFER_CTRL_AUTO_SS_EN to drive slave selects from the request instead of ss_manual.
module spi_xfer_ctrl #(
    parameter int unsigned DW   = 32,
    parameter int unsigned LW   = 5,
    parameter int unsigned SS_W = 8
) (
    input  logic              wb_clk_in,
    input  logic              wb_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DW-1:0]     req_data,
    input  logic [LW-1:0]     req_len,
    input  logic [7:0]        req_div,
    input  logic [SS_W-1:0]   req_ss,
    input  logic              req_lsb,
    input  logic              req_tx_neg,
    input  logic              req_rx_neg,
    input  logic              abort,
    input  logic [SS_W-1:0]   ss_manual,
    output logic              go,
    output logic              tip,
    output logic              last_clk,
    output logic [7:0]        divider,
    input  logic              pos_edge,
    input  logic              neg_edge,
    output logic              mosi,
    input  logic              miso,
    output logic [SS_W-1:0]   ss_pad_o,
    output logic              rx_valid,
    output logic [DW-1:0]     rx_data
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_XFER,
        ST_DONE
    } state_t;

    localparam logic [LW:0] DW_N = (LW+1)'(DW);

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              go_q, go_d;
    logic              tip_q, tip_d;
    logic              last_clk_q, last_clk_d;
    logic [7:0]        divider_q, divider_d;
    logic              mosi_q, mosi_d;
    logic [SS_W-1:0]   ss_q, ss_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DW-1:0]     rx_data_q, rx_data_d;
    logic [DW-1:0]     tx_sr_q, tx_sr_d;
    logic [DW-1:0]     rx_sr_q, rx_sr_d;
    logic [LW+1:0]     edge_left_q, edge_left_d;
    logic [LW:0]       nbits_q, nbits_d;
    logic              lsb_q, lsb_d;
    logic              tx_neg_q, tx_neg_d;
    logic              rx_neg_q, rx_neg_d;

    logic [LW:0]       req_n;
    logic [DW-1:0]     tx_first;
    logic              accept;
    logic              tx_hit;
    logic              rx_hit;

`ifdef SPI_XFER_CTRL_AUTO_SS_EN
    logic [SS_W-1:0]   ss_req_q, ss_req_d;
    logic              ss_manual_unused;
    assign ss_manual_unused = ^ss_manual;
`else
    logic              req_ss_unused;
    assign req_ss_unused = ^req_ss;
`endif

    assign req_n    = (req_len == '0) ? DW_N : {1'b0, req_len};
    // MSB-first words are pre-shifted so the first bit always sits at DW-1.
    assign tx_first = req_lsb ? req_data : (req_data << (DW_N - req_n));
    assign accept   = req_valid && !abort;
    assign tx_hit   = tx_neg_q ? neg_edge : pos_edge;
    assign rx_hit   = rx_neg_q ? neg_edge : pos_edge;

    always_comb begin
        state_d     = state_q;
        go_d        = 1'b0;
        rx_valid_d  = 1'b0;
        divider_d   = divider_q;
        mosi_d      = mosi_q;
        rx_data_d   = rx_data_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        edge_left_d = edge_left_q;
        nbits_d     = nbits_q;
        lsb_d       = lsb_q;
        tx_neg_d    = tx_neg_q;
        rx_neg_d    = rx_neg_q;
`ifdef SPI_XFER_CTRL_AUTO_SS_EN
        ss_req_d    = ss_req_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d     = ST_XFER;
                    go_d        = 1'b1;
                    divider_d   = req_div;
                    nbits_d     = req_n;
                    edge_left_d = {req_n, 1'b0};
                    lsb_d       = req_lsb;
                    tx_neg_d    = req_tx_neg;
                    rx_neg_d    = req_rx_neg;
                    tx_sr_d     = tx_first;
                    rx_sr_d     = '0;
                    mosi_d      = req_lsb ? tx_first[0] : tx_first[DW-1];
`ifdef SPI_XFER_CTRL_AUTO_SS_EN
                    ss_req_d    = req_ss;
`endif
                end
            end
            ST_XFER: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (pos_edge || neg_edge) begin
                    edge_left_d = edge_left_q - (LW+2)'(1);
                    // The final edge never advances MOSI: the word is already fully out.
                    if (tx_hit && (edge_left_q != (LW+2)'(1))) begin
                        tx_sr_d = lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
                        mosi_d  = lsb_q ? tx_sr_d[0] : tx_sr_d[DW-1];
                    end
                    if (rx_hit) begin
                        rx_sr_d = lsb_q ? {miso, rx_sr_q[DW-1:1]} : {rx_sr_q[DW-2:0], miso};
                    end
                    if (edge_left_q == (LW+2)'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (!abort) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = lsb_q ? (rx_sr_q >> (DW_N - nbits_q)) : rx_sr_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d = (state_d == ST_IDLE);
        tip_d       = (state_d == ST_XFER);
        last_clk_d  = (state_d == ST_XFER) && (edge_left_d <= (LW+2)'(1));
`ifdef SPI_XFER_CTRL_AUTO_SS_EN
        ss_d        = (state_d == ST_XFER) ? ~ss_req_d : '1;
`else
        ss_d        = ~ss_manual;
`endif
    end

    always_ff @(posedge wb_clk_in) begin
        if (wb_rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            go_q        <= 1'b0;
            tip_q       <= 1'b0;
            last_clk_q  <= 1'b0;
            divider_q   <= '0;
            mosi_q      <= 1'b0;
            ss_q        <= '1;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            edge_left_q <= '0;
            nbits_q     <= '0;
            lsb_q       <= 1'b0;
            tx_neg_q    <= 1'b0;
            rx_neg_q    <= 1'b0;
`ifdef SPI_XFER_CTRL_AUTO_SS_EN
            ss_req_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            go_q        <= go_d;
            tip_q       <= tip_d;
            last_clk_q  <= last_clk_d;
            divider_q   <= divider_d;
            mosi_q      <= mosi_d;
            ss_q        <= ss_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            edge_left_q <= edge_left_d;
            nbits_q     <= nbits_d;
            lsb_q       <= lsb_d;
            tx_neg_q    <= tx_neg_d;
            rx_neg_q    <= rx_neg_d;
`ifdef SPI_XFER_CTRL_AUTO_SS_EN
            ss_req_q    <= ss_req_d;
`endif
        end
    end

    assign req_ready = req_ready_q;
    assign go        = go_q;
    assign tip       = tip_q;
    assign last_clk  = last_clk_q;
    assign divider   = divider_q;
    assign mosi      = mosi_q;
    assign ss_pad_o  = ss_q;
    assign rx_valid  = rx_valid_q;
    assign rx_data   = rx_data_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: transaction-level model compared every cycle plus literal checks.
// Honours SPI_XFER_CTRL_AUTO_SS_EN the same way as the design.
module tb_spi_xfer_ctrl;

    logic        clk = 1'b0;
    logic        wb_rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_data;
    logic [4:0]  req_len;
    logic [7:0]  req_div;
    logic [7:0]  req_ss;
    logic        req_lsb;
    logic        req_tx_neg;
    logic        req_rx_neg;
    logic        abort;
    logic [7:0]  ss_manual;
    logic        go;
    logic        tip;
    logic        last_clk;
    logic [7:0]  divider;
    logic        pos_edge;
    logic        neg_edge;
    logic        mosi;
    logic        miso;
    logic [7:0]  ss_pad_o;
    logic        rx_valid;
    logic [31:0] rx_data;

    logic        loop_en;
    logic        miso_ext;
    assign miso = loop_en ? mosi : miso_ext;

    always #5 clk = ~clk;

    spi_xfer_ctrl #(.DW(32), .LW(5), .SS_W(8)) dut (
        .wb_clk_in (clk),
        .wb_rst    (wb_rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_len   (req_len),
        .req_div   (req_div),
        .req_ss    (req_ss),
        .req_lsb   (req_lsb),
        .req_tx_neg(req_tx_neg),
        .req_rx_neg(req_rx_neg),
        .abort     (abort),
        .ss_manual (ss_manual),
        .go        (go),
        .tip       (tip),
        .last_clk  (last_clk),
        .divider   (divider),
        .pos_edge  (pos_edge),
        .neg_edge  (neg_edge),
        .mosi      (mosi),
        .miso      (miso),
        .ss_pad_o  (ss_pad_o),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data)
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Transaction-level model: busy/done phase, edges remaining, tx bit index, captured rx bits.
    int          m_st;
    bit          m_go;
    int          m_left;
    int          m_n;
    int          m_k;
    logic [31:0] m_data;
    bit          m_lsb, m_txn, m_rxn;
    logic [7:0]  m_div;
    logic [7:0]  m_ssreq;
    logic [7:0]  m_ss;
    logic        m_mosi;
    bit          m_rxv;
    logic [31:0] m_rxd;
    logic        m_bits[$];

    function automatic logic bit_of(input logic [31:0] d, input int n, input bit lsb, input int k);
        if (k >= n) return 1'b0;
        return lsb ? d[k] : d[n-1-k];
    endfunction

    function automatic logic [31:0] word_of(input int n, input bit lsb);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < m_bits.size() && i < n; i++) begin
            if (lsb) w[i] = m_bits[i];
            else     w[n-1-i] = m_bits[i];
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (wb_rst) begin
            m_st <= 0; m_go <= 1'b0; m_left <= 0; m_div <= 8'h00; m_mosi <= 1'b0;
            m_rxv <= 1'b0; m_rxd <= '0; m_ss <= 8'hFF; m_ssreq <= 8'h00;
        end else begin
            m_go  <= 1'b0;
            m_rxv <= 1'b0;
            m_ss  <= ~ss_manual;
            case (m_st)
                0: if (req_valid && !abort) begin
                    int n;
                    n = (req_len == 0) ? 32 : int'(req_len);
                    m_st <= 1; m_go <= 1'b1; m_n <= n; m_left <= 2 * n; m_k <= 0;
                    m_data <= req_data; m_lsb <= req_lsb; m_txn <= req_tx_neg; m_rxn <= req_rx_neg;
                    m_div <= req_div; m_ssreq <= req_ss;
                    m_mosi <= bit_of(req_data, n, req_lsb, 0);
                    m_bits.delete();
                end
                1: if (abort) m_st <= 0;
                   else if (pos_edge || neg_edge) begin
                    m_left <= m_left - 1;
                    if ((m_txn ? neg_edge : pos_edge) && m_left != 1) begin
                        m_k <= m_k + 1;
                        m_mosi <= bit_of(m_data, m_n, m_lsb, m_k + 1);
                    end
                    if (m_rxn ? neg_edge : pos_edge) m_bits.push_back(miso);
                    if (m_left == 1) m_st <= 2;
                end
                default: begin
                    m_st <= 0;
                    if (!abort) begin
                        m_rxv <= 1'b1;
                        m_rxd <= word_of(m_n, m_lsb);
                    end
                end
            endcase
        end
    end

    // Compare process and event counters, sampled on the falling edge.
    int          rxv_cnt = 0, go_cnt = 0, lc_cnt = 0;
    logic [31:0] last_rx = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("req_ready", {31'd0, req_ready}, {31'd0, m_st == 0});
            chk("go", {31'd0, go}, {31'd0, m_go});
            chk("tip", {31'd0, tip}, {31'd0, m_st == 1});
            chk("last_clk", {31'd0, last_clk}, {31'd0, (m_st == 1) && (m_left <= 1)});
            chk("divider", {24'd0, divider}, {24'd0, m_div});
            chk("mosi", {31'd0, mosi}, {31'd0, m_mosi});
            chk("rx_valid", {31'd0, rx_valid}, {31'd0, m_rxv});
            chk("rx_data", rx_data, m_rxd);
`ifdef SPI_XFER_CTRL_AUTO_SS_EN
            chk("ss_pad_o", {24'd0, ss_pad_o}, {24'd0, (m_st == 1) ? ~m_ssreq : 8'hFF});
`else
            chk("ss_pad_o", {24'd0, ss_pad_o}, {24'd0, m_ss});
`endif
            if (rx_valid) begin rxv_cnt++; last_rx = rx_data; end
            if (go) go_cnt++;
            if (last_clk) lc_cnt++;
        end
    end

    task automatic do_req(input logic [31:0] d, input int len, input logic [7:0] dv,
                          input logic [7:0] ss, input bit lsb, input bit txn, input bit rxn);
        req_data = d; req_len = 5'(len); req_div = dv; req_ss = ss;
        req_lsb = lsb; req_tx_neg = txn; req_rx_neg = rxn; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic edges(input int ne, input int gap);
        for (int i = 0; i < ne; i++) begin
            pos_edge = (i % 2 == 0);
            neg_edge = (i % 2 == 1);
            @(negedge clk);
            pos_edge = 1'b0;
            neg_edge = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    int rx0, go0;

    initial begin
        wb_rst = 1'b1; req_valid = 1'b0; req_data = '0; req_len = '0; req_div = '0;
        req_ss = '0; req_lsb = 1'b0; req_tx_neg = 1'b0; req_rx_neg = 1'b0; abort = 1'b0;
        ss_manual = 8'h00; pos_edge = 1'b0; neg_edge = 1'b0; loop_en = 1'b1; miso_ext = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_ss", {24'd0, ss_pad_o}, 32'h000000FF);
        chk("rst_rx_data", rx_data, 32'h0);
        wb_rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_rxv_count", rxv_cnt, 0);
        chk("idle_tip", {31'd0, tip}, 32'd0);
        chk("idle_ss", {24'd0, ss_pad_o}, 32'h000000FF);

        // MSB first, 8 bits, loopback
        rx0 = rxv_cnt; go0 = go_cnt; lc_cnt = 0;
        do_req(32'h000000A5, 8, 8'd2, 8'h04, 1'b0, 1'b1, 1'b0);
        chk("go_cycle", {31'd0, go}, 32'd1);
        chk("divider_latched", {24'd0, divider}, 32'd2);
`ifdef SPI_XFER_CTRL_AUTO_SS_EN
        chk("auto_ss_go", {24'd0, ss_pad_o}, 32'h000000FB);
`endif
        edges(16, 2);
        repeat (3) @(negedge clk);
        chk("msb8_rx_count", rxv_cnt - rx0, 1);
        chk("msb8_rx_data", last_rx, 32'h000000A5);
        chk("msb8_go_count", go_cnt - go0, 1);
        chk("msb8_last_clk_cycles", lc_cnt, 3);
        chk("msb8_tip_after", {31'd0, tip}, 32'd0);
        chk("divider_held", {24'd0, divider}, 32'd2);

        // LSB first, full 32 bits, back-to-back pulses
        rx0 = rxv_cnt; lc_cnt = 0;
        do_req(32'h12345678, 0, 8'd1, 8'h04, 1'b1, 1'b1, 1'b0);
        edges(64, 0);
        repeat (4) @(negedge clk);
        chk("lsb32_rx_count", rxv_cnt - rx0, 1);
        chk("lsb32_rx_data", last_rx, 32'h12345678);
        chk("lsb32_last_clk_cycles", lc_cnt, 1);

        // Abort after 5 edges
        rx0 = rxv_cnt;
        do_req(32'h0000005A, 8, 8'd4, 8'h10, 1'b0, 1'b1, 1'b0);
        edges(5, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_tip", {31'd0, tip}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_ss", {24'd0, ss_pad_o}, 32'h000000FF);
        repeat (3) @(negedge clk);
        chk("abort_no_rx", rxv_cnt - rx0, 0);
        chk("abort_rx_data_kept", rx_data, 32'h12345678);

        // Abort wins over a simultaneous request in IDLE
        go0 = go_cnt;
        req_data = 32'h000000FF; req_len = 5'd8; abort = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        abort = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle_no_go", go_cnt - go0, 0);
        chk("abort_idle_tip", {31'd0, tip}, 32'd0);

        // Request after abort completes normally
        rx0 = rxv_cnt;
        do_req(32'h000000C3, 8, 8'd3, 8'h01, 1'b0, 1'b1, 1'b0);
        edges(16, 1);
        repeat (3) @(negedge clk);
        chk("after_abort_rx_data", last_rx, 32'h000000C3);
        chk("after_abort_rx_count", rxv_cnt - rx0, 1);

        // tx on pos / rx on neg, 5 bits, MISO tied high
        loop_en = 1'b0; miso_ext = 1'b1; rx0 = rxv_cnt;
        do_req(32'h00000015, 5, 8'd3, 8'h81, 1'b0, 1'b0, 1'b1);
        edges(10, 1);
        repeat (3) @(negedge clk);
        chk("len5_rx_data", last_rx, 32'h0000001F);
        loop_en = 1'b1;

        ss_manual = 8'h3C;
        @(negedge clk);
`ifdef SPI_XFER_CTRL_AUTO_SS_EN
        chk("ss_manual_ignored", {24'd0, ss_pad_o}, 32'h000000FF);
`else
        chk("ss_manual_level", {24'd0, ss_pad_o}, 32'h000000C3);
`endif

        // Reset mid-transfer with a request pending
        do_req(32'h000000F0, 8, 8'd7, 8'h02, 1'b0, 1'b1, 1'b0);
        edges(6, 0);
        wb_rst = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_go", {31'd0, go}, 32'd0);
        chk("rst_mid_tip", {31'd0, tip}, 32'd0);
        chk("rst_mid_divider", {24'd0, divider}, 32'd0);
        chk("rst_mid_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_mid_ss", {24'd0, ss_pad_o}, 32'h000000FF);
        chk("rst_mid_rx_data", rx_data, 32'h0);
        wb_rst = 1'b0; req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_stays_idle", {31'd0, tip}, 32'd0);

        // Full-width MSB-first transfer to exercise the boundary bits
        do_req(32'h80000001, 0, 8'd5, 8'h40, 1'b0, 1'b1, 1'b0);
        edges(64, 1);
        repeat (3) @(negedge clk);
        chk("msb32_rx_data", last_rx, 32'h80000001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
Transfer sequencer for the SPI master serial-clock generator. It accepts one transfer request at a time and drives `go`, `tip`, `last_clk` and `divider` into the clock generator. It consumes the generator's pre-edge pulses to shift MOSI out and sample MISO in, drives slave selects, and returns the received word with a one-cycle valid. It sits between the Wishbone register file and the clock generator / pad logic.

Parameters:
DW, 32, maximum transfer length in bits and width of the data paths
LW, 5, width of the length field; must equal log2(DW)
SS_W, 8, number of slave-select lines

Ports:
wb_clk_in  in  1  system clock
wb_rst  in  1  reset, synchronous, active-high
req_valid  in  1  transfer request
req_ready  out  1  controller can accept a request
req_data  in  DW  transmit word
req_len  in  LW  bit count; 0 = DW bits
req_div  in  8  clock divider for this transfer
req_ss  in  SS_W  slave-select mask, 1 = select
req_lsb  in  1  1 = LSB first, 0 = MSB first
req_tx_neg  in  1  1 = MOSI changes on neg-edge pulses, 0 = on pos-edge pulses
req_rx_neg  in  1  1 = MISO sampled on neg-edge pulses, 0 = on pos-edge pulses
abort  in  1  cancel the current transfer
ss_manual  in  SS_W  manual select levels, used only without the optional feature
go  out  1  one-cycle start pulse to the clock generator
tip  out  1  transfer in progress, to the clock generator
last_clk  out  1  final-edge marker, to the clock generator
divider  out  8  latched divider, to the clock generator
pos_edge  in  1  pulse one cycle before an sclk rise (generator `cpol_0`)
neg_edge  in  1  pulse one cycle before an sclk fall (generator `cpol_1`)
mosi  out  1  serial data out
miso  in  1  serial data in
ss_pad_o  out  SS_W  slave selects, active-low
rx_valid  out  1  one-cycle pulse, `rx_data` valid
rx_data  out  DW  received word, right-aligned

Behaviour:
- Reset: all outputs are synchronous on `wb_clk_in`; `wb_rst` is sampled on the rising edge.
  - State = IDLE.
  - `req_ready` = 1.
  - `go`, `tip`, `last_clk`, `mosi`, `rx_valid` = 0.
  - `divider` = 0, `rx_data` = 0.
  - `ss_pad_o` = all 1.
- States:
  - IDLE: `req_ready` = 1. On `req_valid` & `req_ready`:
    - latch the request fields;
    - N = `req_len`, or DW when `req_len` = 0;
    - `edge_left` = 2N (width LW+2);
    - `go` = 1 for exactly one cycle;
    - `mosi` = first tx bit (bit N-1 if MSB first, bit 0 if LSB first);
    - next state = XFER.
  - XFER: `tip` = 1 and `req_ready` = 0.
    - Each `pos_edge` or `neg_edge` pulse decrements `edge_left`. Pulses are mutually exclusive.
    - A pulse matching `tx_neg` advances `mosi` to the next tx bit. The tx advance is skipped on the pulse that also consumes the last edge.
    - A pulse matching `rx_neg` samples `miso` into the rx shift register, in that same cycle.
    - `last_clk` = 1 while `edge_left` <= 1.
    - When `edge_left` reaches 0: `tip` = 0 from the next cycle, next state = DONE.
  - DONE (1 cycle): `rx_data` updated, `rx_valid` = 1, next state = IDLE.
- `rx_data` alignment: exactly N bits captured, right-aligned, upper DW-N bits 0.
  - MSB first: the first received bit lands at bit N-1.
  - LSB first: the first received bit lands at bit 0.
- `divider` output holds the latched value until the next accepted request. It is not cleared at end of transfer.
- Request back-to-back: a request can be accepted in the IDLE cycle directly after DONE. Minimum request-to-request spacing is 2N edges + 3 cycles.
- `abort` in XFER or DONE:
  - next cycle state = IDLE;
  - `tip` = 0, `last_clk` = 0;
  - no `rx_valid`, `rx_data` unchanged;
  - selects released.
- `abort` in IDLE is ignored. `abort` together with `req_valid` in IDLE: abort wins and the request is not accepted.
- `wb_rst` mid-transfer: returns all outputs to their reset values on the next edge. Reset overrides `abort` and requests.
- Pulses arriving in IDLE or DONE are ignored.

Optional Feature:
`SPI_XFER_CTRL_AUTO_SS_EN`:
- Defined: `ss_pad_o` = ~`req_ss_latched` from the `go` cycle through the last XFER cycle, and all 1 otherwise. `ss_manual` is unused.
- Undefined: `ss_pad_o` = ~`ss_manual` (registered, 1-cycle latency) at all times, independent of the state; the latched `req_ss` is unused.

Test Plan:
- Reset, then idle 10 cycles -> `req_ready`=1, `tip`=0, `ss_pad_o`=8'hFF, `rx_valid` never 1.
- MSB, len=8, div=2, data=8'hA5, `tx_neg`=1, `rx_neg`=0, `miso` looped to `mosi` -> `go` 1 cycle, exactly 16 edge pulses, `rx_data`=32'h000000A5, `rx_valid` one cycle, `tip` low afterwards.
- LSB, len=0 (32 bits), data=32'h1234_5678, loopback -> `rx_data`=32'h1234_5678; `last_clk` high only on the final edge-count window.
- With `SPI_XFER_CTRL_AUTO_SS_EN`, req_ss=8'h04 -> `ss_pad_o`=8'hFB from the `go` cycle through the last XFER cycle, 8'hFF otherwise.
- `abort` after 5 edges of an 8-bit transfer -> `tip`=0 next cycle, no `rx_valid`, next request accepted and completes correctly.
- `wb_rst` asserted mid-transfer together with `req_valid`=1 -> all outputs at reset values, no request accepted that cycle.
